// File: rtl/equilibrium_maxxing_pkg.sv
// Shared constants for the equilibrium game datapath: FSM encodings, LED count default
// and the LFSR width/taps used by every pseudo-random source.
package equilibrium_maxxing_pkg;

    localparam int N_LEDS_DEF = 11;
    localparam int DB_W       = 2;

    localparam int          LFSR_W    = 16;
    // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [DB_W-1:0] ST_IDLE    = 2'b00;
    localparam logic [DB_W-1:0] ST_SORTEIA = 2'b01;
    localparam logic [DB_W-1:0] ST_ESPERA  = 2'b10;
    localparam logic [DB_W-1:0] ST_ACERTO  = 2'b11;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free running, loaded with SEED while reset is low.
// SEED must be non-zero or the register locks up at zero.
module lfsr16
    import equilibrium_maxxing_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/jogada_led_target.sv
// Play responder: draws a random target LED on each request, waits for the lever balance to hold it,
// and reports a hit (ponto_evento) or a timeout (erro_evento). Optional macro FADE_PWM_EN adds LED fading.
module jogada_led_target
    import equilibrium_maxxing_pkg::*;
#(
    parameter int          N_LEDS         = N_LEDS_DEF,
    parameter int          POS_W          = 16,
    parameter int unsigned HOLD_BASE      = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gerar_nova_jogada,
    input  logic [1:0]        nivel,
    input  logic [POS_W-1:0]  alavanca1,
    input  logic [POS_W-1:0]  alavanca2,
    output logic [N_LEDS-1:0] leds,
    output logic              ponto_evento,
    output logic              erro_evento,
    output logic [3:0]        alvo_idx,
    output logic [DB_W-1:0]   db_estado
);

    logic [LFSR_W-1:0] lfsr;
    logic [DB_W-1:0]   state;
    logic              gerar_q;
    logic [3:0]        prev_idx;
    logic              prev_valid;
    logic [31:0]       hold_req;
    logic [31:0]       hold_cnt;
    logic [31:0]       timer;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .q     (lfsr)
    );

    logic req_rise;
    assign req_rise = gerar_nova_jogada & ~gerar_q;

    // Lever balance: half the signed difference, offset to unsigned, scaled onto the LED bar
    logic signed [POS_W:0] diff;
    logic [POS_W-1:0]      pos_off;
    logic [POS_W+4:0]      prod;
    logic [3:0]            pos_idx;
    logic                  unused_bits;

    assign diff        = $signed({alavanca1[POS_W-1], alavanca1}) - $signed({alavanca2[POS_W-1], alavanca2});
    assign pos_off     = diff[POS_W:1] ^ {1'b1, {(POS_W-1){1'b0}}};
    assign prod        = {5'd0, pos_off} * (POS_W+5)'(N_LEDS);
    assign pos_idx     = prod[POS_W+3:POS_W];
    assign unused_bits = ^{diff[0], prod[POS_W+4]};

    logic [3:0] cand_raw;
    logic [3:0] cand;

    always_comb begin
        cand_raw = 4'(lfsr % 16'(N_LEDS));
        cand     = cand_raw;
        if (prev_valid && cand_raw == prev_idx) begin
            cand = (cand_raw == 4'(N_LEDS - 1)) ? 4'd0 : cand_raw + 4'd1;
        end
    end

    logic match;
    logic hit;
    logic timeout;

    assign match   = (pos_idx == alvo_idx);
    assign hit     = match && (hold_cnt == hold_req - 32'd1);
    assign timeout = (timer == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            gerar_q    <= 1'b0;
            alvo_idx   <= 4'd0;
            prev_idx   <= 4'd0;
            prev_valid <= 1'b0;
            hold_req   <= 32'd0;
            hold_cnt   <= 32'd0;
            timer      <= 32'd0;
        end else begin
            gerar_q <= gerar_nova_jogada;
            case (state)
                ST_IDLE: begin
                    if (req_rise) state <= ST_SORTEIA;
                end
                ST_SORTEIA: begin
                    alvo_idx   <= cand;
                    prev_idx   <= cand;
                    prev_valid <= 1'b1;
                    hold_req   <= 32'(HOLD_BASE) * ({30'd0, nivel} + 32'd1);
                    hold_cnt   <= 32'd0;
                    timer      <= 32'd0;
                    state      <= ST_ESPERA;
                end
                ST_ESPERA: begin
                    hold_cnt <= match ? hold_cnt + 32'd1 : 32'd0;
                    timer    <= timer + 32'd1;
                    // a fresh request abandons the play silently; a hit beats a coincident timeout
                    if (req_rise)     state <= ST_SORTEIA;
                    else if (hit)     state <= ST_ACERTO;
                    else if (timeout) state <= ST_IDLE;
                end
                ST_ACERTO: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ponto_evento = (state == ST_ACERTO);
    assign erro_evento  = (state == ST_ESPERA) && timeout && !hit && !req_rise;
    assign db_estado    = state;

    logic [N_LEDS-1:0] target_onehot;
    assign target_onehot = N_LEDS'(1) << alvo_idx;

`ifdef FADE_PWM_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);

    logic [7:0] pwm_cnt;
    logic [7:0] duty;

    always_ff @(posedge clock) begin
        if (!reset) pwm_cnt <= 8'd0;
        else        pwm_cnt <= pwm_cnt + 8'd1;
    end

    // duty follows the top of the elapsed time, so the LED brightens as the deadline nears
    assign duty = timer[TW-1 -: 8];

    always_comb begin
        leds = '0;
        if (state == ST_ESPERA && (match || pwm_cnt < duty)) leds = target_onehot;
    end
`else
    always_comb begin
        leds = '0;
        if (state == ST_ESPERA) leds = target_onehot;
    end
`endif

endmodule

// File: tb/tb_jogada_led_target.sv
// Bench for jogada_led_target with HOLD_BASE=4 and TIMEOUT_CYCLES=100; pulses are scored against
// an expected queue of {erro, ponto, cycle} entries.
module tb_jogada_led_target;

    localparam int          N       = 11;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        gerar_nova_jogada = 1'b0;
    logic [1:0]  nivel = 2'd0;
    logic [15:0] alavanca1 = 16'd0;
    logic [15:0] alavanca2 = 16'd0;
    logic [N-1:0] leds;
    logic        ponto_evento;
    logic        erro_evento;
    logic [3:0]  alvo_idx;
    logic [1:0]  db_estado;

    jogada_led_target #(
        .N_LEDS(N), .POS_W(16), .HOLD_BASE(4), .TIMEOUT_CYCLES(100), .LFSR_SEED(SEED)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .gerar_nova_jogada (gerar_nova_jogada),
        .nivel             (nivel),
        .alavanca1         (alavanca1),
        .alavanca2         (alavanca2),
        .leds              (leds),
        .ponto_evento      (ponto_evento),
        .erro_evento       (erro_evento),
        .alvo_idx          (alvo_idx),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];

    logic [15:0] m_lfsr;
    logic [3:0]  m_prev = 4'd0;
    logic        m_prev_valid = 1'b0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // scoreboard: every pulse must match the oldest expected {erro, ponto, cycle}
    always @(negedge clock) begin
        if (ponto_evento || erro_evento) begin
            logic [33:0] got;
            logic [33:0] e;
            checks++;
            got = {erro_evento, ponto_evento, 32'(cyc)};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected got erro=%0b ponto=%0b cyc=%0d required no pulse",
                         erro_evento, ponto_evento, cyc);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL event_match got erro=%0b ponto=%0b cyc=%0d required erro=%0b ponto=%0b cyc=%0d",
                             got[33], got[32], got[31:0], e[33], e[32], e[31:0]);
                end
            end
        end
    end

    // lever pair whose balance lands in the middle of LED bin idx
    task automatic aim(input int idx);
        int p;
        p = ((2 * idx + 1) * 65536) / 22 - 32768;
        alavanca1 = 16'(p);
        alavanca2 = 16'(-p);
    endtask

    // called on a negedge; returns on the first ESPERA negedge with the modelled target
    task automatic start_play(output logic [3:0] t);
        int cand;
        gerar_nova_jogada = 1'b1;
        @(negedge clock);
        checks++;
        if (db_estado !== 2'b01) begin
            errors++; $display("FAIL sorteia_state got %b required 01", db_estado);
        end
        cand = int'(m_lfsr) % N;
        if (m_prev_valid && cand == int'(m_prev)) cand = (cand + 1) % N;
        m_prev = 4'(cand);
        m_prev_valid = 1'b1;
        gerar_nova_jogada = 1'b0;
        @(negedge clock);
        checks++;
        if (db_estado !== 2'b10) begin
            errors++; $display("FAIL espera_state got %b required 10", db_estado);
        end
        checks++;
        if (alvo_idx !== 4'(cand) || alvo_idx >= 4'd11) begin
            errors++; $display("FAIL target_idx got %0d required %0d", alvo_idx, cand);
        end
        checks++;
        if (leds !== N'(1) << cand) begin
            errors++; $display("FAIL target_leds got %b required %b", leds, N'(1) << cand);
        end
        t = 4'(cand);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (leds !== '0)       begin errors++; $display("FAIL reset_leds got %b required 0", leds); end
        checks++; if (ponto_evento !== 1'b0) begin errors++; $display("FAIL reset_ponto got %b required 0", ponto_evento); end
        checks++; if (erro_evento !== 1'b0)  begin errors++; $display("FAIL reset_erro got %b required 0", erro_evento); end
        checks++; if (db_estado !== 2'b00)   begin errors++; $display("FAIL reset_state got %b required 00", db_estado); end
        checks++; if (alvo_idx !== 4'd0)     begin errors++; $display("FAIL reset_alvo got %0d required 0", alvo_idx); end
        reset = 1'b1;
        m_prev_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clock);
    endtask

    task automatic test_hit;
        logic [3:0] t;
        nivel = 2'd0;
        start_play(t);
        aim(int'(t));
        exp_q.push_back({2'b01, 32'(cyc + 4)});
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (ponto_evento !== 1'b0 || db_estado !== 2'b10) begin
                errors++; $display("FAIL hit_early got ponto=%b state=%b required 0/10", ponto_evento, db_estado);
            end
        end
        @(negedge clock);
        checks++;
        if (ponto_evento !== 1'b1 || leds !== '0 || db_estado !== 2'b11) begin
            errors++; $display("FAIL hit_pulse got ponto=%b leds=%b state=%b required 1/0/11", ponto_evento, leds, db_estado);
        end
        @(negedge clock);
        checks++;
        if (ponto_evento !== 1'b0 || db_estado !== 2'b00 || leds !== '0) begin
            errors++; $display("FAIL hit_after got ponto=%b state=%b leds=%b required 0/00/0", ponto_evento, db_estado, leds);
        end
        aim((int'(t) + 5) % N);
    endtask

    task automatic test_rematch;
        logic [3:0] t;
        nivel = 2'd3;
        start_play(t);
        nivel = 2'd0;
        aim(int'(t));
        repeat (10) @(negedge clock);
        aim((int'(t) + 5) % N);
        @(negedge clock);
        aim(int'(t));
        exp_q.push_back({2'b01, 32'(cyc + 16)});
        repeat (15) begin
            @(negedge clock);
            checks++;
            if (ponto_evento !== 1'b0 || db_estado !== 2'b10) begin
                errors++; $display("FAIL rematch_early got ponto=%b state=%b required 0/10", ponto_evento, db_estado);
            end
        end
        @(negedge clock);
        checks++;
        if (ponto_evento !== 1'b1) begin
            errors++; $display("FAIL rematch_pulse got %b required 1", ponto_evento);
        end
        @(negedge clock);
        aim((int'(t) + 5) % N);
    endtask

    task automatic test_timeout;
        logic [3:0] t;
        nivel = 2'd0;
        start_play(t);
        aim((int'(t) + 5) % N);
        exp_q.push_back({2'b10, 32'(cyc + 99)});
        repeat (98) @(negedge clock);
        checks++;
        if (erro_evento !== 1'b0 || db_estado !== 2'b10) begin
            errors++; $display("FAIL timeout_early got erro=%b state=%b required 0/10", erro_evento, db_estado);
        end
        @(negedge clock);
        checks++;
        if (erro_evento !== 1'b1 || ponto_evento !== 1'b0 || leds !== N'(1) << t) begin
            errors++; $display("FAIL timeout_pulse got erro=%b ponto=%b leds=%b required 1/0/%b",
                               erro_evento, ponto_evento, leds, N'(1) << t);
        end
        @(negedge clock);
        checks++;
        if (erro_evento !== 1'b0 || db_estado !== 2'b00 || leds !== '0) begin
            errors++; $display("FAIL timeout_after got erro=%b state=%b leds=%b required 0/00/0", erro_evento, db_estado, leds);
        end
    endtask

    task automatic test_hit_and_timeout;
        logic [3:0] t;
        nivel = 2'd0;
        start_play(t);
        aim((int'(t) + 5) % N);
        repeat (96) @(negedge clock);
        aim(int'(t));
        exp_q.push_back({2'b01, 32'(cyc + 4)});
        repeat (3) @(negedge clock);
        checks++;
        if (erro_evento !== 1'b0 || db_estado !== 2'b10) begin
            errors++; $display("FAIL tie_no_erro got erro=%b state=%b required 0/10", erro_evento, db_estado);
        end
        @(negedge clock);
        checks++;
        if (ponto_evento !== 1'b1 || erro_evento !== 1'b0) begin
            errors++; $display("FAIL tie_ponto got ponto=%b erro=%b required 1/0", ponto_evento, erro_evento);
        end
        @(negedge clock);
        aim((int'(t) + 5) % N);
    endtask

    task automatic test_reset_mid;
        logic [3:0] t;
        start_play(t);
        aim((int'(t) + 5) % N);
        repeat ($urandom_range(2, 20)) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (leds !== '0 || alvo_idx !== 4'd0 || db_estado !== 2'b00 || ponto_evento !== 1'b0 || erro_evento !== 1'b0) begin
            errors++; $display("FAIL reset_mid got leds=%b alvo=%0d state=%b ponto=%b erro=%b required all 0",
                               leds, alvo_idx, db_estado, ponto_evento, erro_evento);
        end
        reset = 1'b1;
        m_prev_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_back_to_back;
        logic [3:0] t;
        logic [3:0] last;
        last = 4'd0;
        for (int i = 0; i < 12; i++) begin
            start_play(t);
            if (i > 0) begin
                checks++;
                if (alvo_idx === last) begin
                    errors++; $display("FAIL repeat_target got %0d required not %0d", alvo_idx, last);
                end
            end
            last = t;
        end
        aim((int'(t) + 5) % N);
        exp_q.push_back({2'b10, 32'(cyc + 99)});
        repeat (101) @(negedge clock);
    endtask

    initial begin
        aim(5);
        test_reset();
        test_hit();
        test_rematch();
        test_timeout();
        test_hit_and_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL pending_events got %0d outstanding required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
